// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : Per-button 2-flop synchroniser plus counter-based debounce FSM,
//            producing a clean registered level and 1-cycle press/release strobes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LO     = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HI     = 2'd2,
    ST_CHK_LO = 2'd3
  } state_e;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic             s1_q;
    logic             s_q;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    // Strobes default low every cycle so they can only ever last one clock.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        ST_LO: begin
          if (s_q) begin
            state_d = ST_CHK_HI;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_CHK_HI: begin
          if (!s_q) begin
            state_d = ST_LO;
          end else if (cnt_q == CNT_MAX) begin
            state_d = ST_HI;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_HI: begin
          if (!s_q) begin
            state_d = ST_CHK_LO;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_CHK_LO: begin
          if (s_q) begin
            state_d = ST_HI;
          end else if (cnt_q == CNT_MAX) begin
            state_d   = ST_LO;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_LO;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q      <= 1'b0;
        s_q       <= 1'b0;
        state_q   <= ST_LO;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1_q      <= btn_raw[i];
        s_q       <= s1_q;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce.sv
// ============================================================================
// Module   : tb_btn_debounce
// Purpose  : Directed self-checking bench for btn_debounce (DEBOUNCE_CYCLES=4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_btn_debounce;

  localparam int NUM_BTN = 2;
  localparam int DEB     = 4;

  logic               clk;
  logic               rst;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  int n_checks;
  int n_fail;

  btn_debounce #(
    .NUM_BTN         (NUM_BTN),
    .DEBOUNCE_CYCLES (DEB)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] lvl,
                          input logic [1:0] prs, input logic [1:0] rel);
    chk({tag, ".level"},   32'(btn_level),   32'(lvl));
    chk({tag, ".press"},   32'(btn_press),   32'(prs));
    chk({tag, ".release"}, 32'(btn_release), 32'(rel));
  endtask

  // Holds btn_raw constant; n=0 is the edge where s1 first samples it.
  // The level flips and the strobe fires at n == acc.
  task automatic run_phase(input string tag, input logic [1:0] raw, input int ncyc,
                           input int acc, input logic [1:0] lvl_before,
                           input logic [1:0] lvl_after, input logic [1:0] prs,
                           input logic [1:0] rel);
    btn_raw = raw;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      chk_outs($sformatf("%s[%0d]", tag, n),
               (n >= acc) ? lvl_after : lvl_before,
               (n == acc) ? prs : 2'b00,
               (n == acc) ? rel : 2'b00);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    btn_raw  = 2'b00;

    // Reset held for three cycles
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk_outs($sformatf("reset[%0d]", n), 2'b00, 2'b00, 2'b00);
    end

    // Clean press on channel 0
    rst = 1'b0;
    run_phase("press0", 2'b01, 8, DEB + 1, 2'b00, 2'b01, 2'b01, 2'b00);

    // Bounce on channel 1: high 2, low 1, high 2, then low
    for (int n = 0; n < 12; n++) begin
      btn_raw = {(n == 0 || n == 1 || n == 3 || n == 4), 1'b1};
      @(negedge clk);
      chk_outs($sformatf("bounce1[%0d]", n), 2'b01, 2'b00, 2'b00);
    end
    run_phase("press1", 2'b11, 10, DEB + 1, 2'b01, 2'b11, 2'b10, 2'b00);

    // Release on channel 0 with a one-cycle glitch; final fall sampled at n=4
    for (int n = 0; n < 12; n++) begin
      btn_raw = {1'b1, (n == 3)};
      @(negedge clk);
      chk_outs($sformatf("release0[%0d]", n),
               (n < 9) ? 2'b11 : 2'b10,
               2'b00,
               (n == 9) ? 2'b01 : 2'b00);
    end

    // Channel 0 rises and reaches CHK_HI with cnt=2, then reset hits
    run_phase("prechk", 2'b11, 4, 99, 2'b10, 2'b10, 2'b00, 2'b00);
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      chk_outs($sformatf("midrst[%0d]", n), 2'b00, 2'b00, 2'b00);
    end
    rst = 1'b0;
    run_phase("postrst", 2'b11, 8, DEB + 1, 2'b00, 2'b11, 2'b11, 2'b00);

    // Simultaneous release then simultaneous press on both channels
    run_phase("simrel", 2'b00, 8, DEB + 1, 2'b11, 2'b00, 2'b00, 2'b11);
    run_phase("simprs", 2'b11, 8, DEB + 1, 2'b00, 2'b11, 2'b11, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
